// File: rtl/opr_host_if.sv
// opr_host_if: operand-in and result-out handshake bundle for opr_host.
// master = producer/consumer side (bench or host), slave = opr_host.
interface opr_host_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/opr_host.sv
// opr_host: queues operand pairs, issues one pair per frame to an external
// formula datapath, captures its result one frame later into a small result
// buffer and streams results out with valid/ready.
// Optional feature macro: OPR_HOST_STATS_EN adds the frames_done counter port.
module opr_host #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FRAME_LEN  = 5,
    parameter int unsigned RES_DEPTH  = 2
) (
    input  logic       clock,
    input  logic       reset,
    opr_host_if.slave  bus,
    output logic [3:0] opr_a,
    output logic [3:0] opr_b,
    input  logic [3:0] opr_cout,
    output logic       frame_sync,
`ifdef OPR_HOST_STATS_EN
    output logic [7:0] frames_done,
`endif
    output logic       busy
);
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW = FAW + 1;
    localparam logic [2:0]     SLOT_LAST = 3'(FRAME_LEN - 1);
    localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);
    localparam logic [1:0]     RES_LAST  = 2'(RES_DEPTH - 1);
    localparam logic [3:0]     RES_MAX   = 4'(RES_DEPTH);

    logic [2:0]     slot_q, slot_d;
    logic [7:0]     fifo_mem_q [FIFO_DEPTH];
    logic [7:0]     fifo_mem_d [FIFO_DEPTH];
    logic [FAW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [3:0]     res_mem_q [4];
    logic [3:0]     res_mem_d [4];
    logic [1:0]     res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [2:0]     res_cnt_q, res_cnt_d;
    logic           inflight_q, inflight_d;
    logic [3:0]     opr_a_q, opr_a_d, opr_b_q, opr_b_d;
`ifdef OPR_HOST_STATS_EN
    logic [7:0]     frames_done_q, frames_done_d;
`endif

    logic at_slot0, push, issue, capture, res_pop, space_ok;
    logic in_ready_int, out_valid_int;

    // Handshake qualifiers; in_ready uses pre-pop occupancy, so no full bypass.
    always_comb begin
        in_ready_int  = !reset && (fifo_cnt_q != FIFO_FULL);
        out_valid_int = !reset && (res_cnt_q != 3'd0);
        at_slot0      = (slot_q == 3'd0);
        push          = bus.in_valid && in_ready_int;
        res_pop       = out_valid_int && bus.out_ready;
        // Reserve a result slot for every frame in flight before issuing.
        space_ok      = ({1'b0, res_cnt_q} + {3'b000, inflight_q}) < RES_MAX;
        issue         = at_slot0 && (fifo_cnt_q != '0) && space_ok;
        capture       = at_slot0 && inflight_q;
    end

    // Next-state for slot counter, operand FIFO, issue registers and in-flight flag.
    always_comb begin
        slot_d     = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
        fifo_mem_d = fifo_mem_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        opr_a_d    = opr_a_q;
        opr_b_d    = opr_b_q;
        inflight_d = inflight_q;
        if (push) begin
            fifo_mem_d[fifo_wr_q] = {bus.in_a, bus.in_b};
            fifo_wr_d             = fifo_wr_q + FAW'(1);
        end
        if (capture) begin
            inflight_d = 1'b0;
        end
        if (issue) begin
            {opr_a_d, opr_b_d} = fifo_mem_q[fifo_rd_q];
            fifo_rd_d          = fifo_rd_q + FAW'(1);
            inflight_d         = 1'b1;
        end
        if (push && !issue) begin
            fifo_cnt_d = fifo_cnt_q + FCW'(1);
        end else if (!push && issue) begin
            fifo_cnt_d = fifo_cnt_q - FCW'(1);
        end
    end

    // Next-state for the result buffer (capture at slot 0, pop on handshake).
    always_comb begin
        res_mem_d = res_mem_q;
        res_wr_d  = res_wr_q;
        res_rd_d  = res_rd_q;
        res_cnt_d = res_cnt_q;
        if (capture) begin
            res_mem_d[res_wr_q] = opr_cout;
            res_wr_d            = (res_wr_q == RES_LAST) ? 2'd0 : res_wr_q + 2'd1;
        end
        if (res_pop) begin
            res_rd_d = (res_rd_q == RES_LAST) ? 2'd0 : res_rd_q + 2'd1;
        end
        if (capture && !res_pop) begin
            res_cnt_d = res_cnt_q + 3'd1;
        end else if (!capture && res_pop) begin
            res_cnt_d = res_cnt_q - 3'd1;
        end
    end

`ifdef OPR_HOST_STATS_EN
    // Captured-result counter, wraps naturally at 8 bits.
    always_comb begin
        frames_done_d = frames_done_q;
        if (capture) begin
            frames_done_d = frames_done_q + 8'd1;
        end
    end
`endif

    // Control state with synchronous reset; reset discards everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q     <= 3'd0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            res_wr_q   <= 2'd0;
            res_rd_q   <= 2'd0;
            res_cnt_q  <= 3'd0;
            inflight_q <= 1'b0;
            opr_a_q    <= 4'd0;
            opr_b_q    <= 4'd0;
        end else begin
            slot_q     <= slot_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            res_wr_q   <= res_wr_d;
            res_rd_q   <= res_rd_d;
            res_cnt_q  <= res_cnt_d;
            inflight_q <= inflight_d;
            opr_a_q    <= opr_a_d;
            opr_b_q    <= opr_b_d;
        end
    end

    // Storage arrays need no reset: entries are only read when counts say valid.
    always_ff @(posedge clock) begin
        fifo_mem_q <= fifo_mem_d;
        res_mem_q  <= res_mem_d;
    end

`ifdef OPR_HOST_STATS_EN
    // Stats counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            frames_done_q <= 8'd0;
        end else begin
            frames_done_q <= frames_done_d;
        end
    end
    assign frames_done = frames_done_q;
`endif

    // Outputs; out_data is forced to zero whenever no result is presented.
    always_comb begin
        bus.in_ready  = in_ready_int;
        bus.out_valid = out_valid_int;
        bus.out_data  = out_valid_int ? res_mem_q[res_rd_q] : 4'd0;
        opr_a         = opr_a_q;
        opr_b         = opr_b_q;
        frame_sync    = !reset && at_slot0;
        busy          = !reset && ((fifo_cnt_q != '0) || inflight_q);
    end
endmodule

// File: doc/opr_host.md
OPR_HOST -- requirements
Module: opr_host

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: operand FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter FRAME_LEN, default 5: cycles per datapath computation frame, 2..8.
REQ-003 SHALL have parameter RES_DEPTH, default 2: result buffer entries, 1..4.
REQ-004 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  operand pair offered.
REQ-007 SHALL have port in_ready  out  1  operand FIFO not full.
REQ-008 SHALL have ports in_a, in_b  in  4 each  operand pair.
REQ-009 SHALL have ports opr_a, opr_b  out  4 each  operands driven to the formula datapath.
REQ-010 SHALL have port opr_cout  in  4  datapath result.
REQ-011 SHALL have port frame_sync  out  1  one-cycle pulse at slot 0 of every frame.
REQ-012 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  4  result stream.
REQ-013 SHALL have port busy  out  1  high while any operand is queued or any frame is in flight.

Function
REQ-014 SHALL run a free-running slot counter 0..FRAME_LEN-1, wrapping to 0; frame_sync = (slot==0).
REQ-015 SHALL accept an operand pair on any cycle with in_valid && in_ready; FIFO order preserved.
REQ-016 SHALL at slot 0 issue a frame (pop FIFO head into opr_a/opr_b) only if FIFO non-empty and (results buffered + frames in flight) < RES_DEPTH.
REQ-017 SHALL hold opr_a/opr_b constant for the entire frame; they change only at slot 0 of an issuing frame.
REQ-018 SHALL, when no frame issues, keep opr_a/opr_b at their last values and mark the frame idle.
REQ-019 SHALL capture opr_cout into the result buffer at slot 0 following an issued frame (latency FRAME_LEN cycles from issue), in the same cycle as any new issue.
REQ-020 SHALL present the result buffer head on out_data with out_valid; an entry pops on out_valid && out_ready.
REQ-021 SHALL handle simultaneous push and pop of the operand FIFO when full: in_ready reflects occupancy before the cycle's pop (no same-cycle bypass).
REQ-022 SHALL handle simultaneous capture and pop of the result buffer with count unchanged.
REQ-023 SHALL never drop or duplicate a result; the backpressure rule of REQ-016 guarantees buffer space at capture.
REQ-024 SHALL track at most one frame in flight.
REQ-025 SHALL drive busy = FIFO non-empty || frame in flight.

Reset
REQ-026 SHALL on reset clear slot counter to 0, empty both buffers, clear in-flight flag.
REQ-027 SHALL during and after reset drive in_ready=0 while reset is high, then 1; out_valid=0; out_data=0; opr_a=opr_b=0; busy=0; frame_sync=0 while reset high.
REQ-028 SHALL on reset mid-frame discard the in-flight frame and all queued data; first frame_sync follows the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with OPR_HOST_STATS_EN defined, add output frames_done (8 bits): count of captured results, reset 0, wraps 255->0.
REQ-030 SHALL, without OPR_HOST_STATS_EN, omit frames_done port and counter entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover single pair: a=3,b=4 pushed before slot 0 -> opr_a=3,opr_b=4 held 5 cycles; stub cout=7 -> out_data=7, out_valid 5 cycles after issue.
REQ-032 SHALL cover FIFO full: 4 pushes with out_ready=1, no issue yet -> in_ready=0 on 5th offer; pair not accepted.
REQ-033 SHALL cover backpressure: out_ready=0, 3 pairs queued, RES_DEPTH=2 -> exactly 2 frames issue, third waits; out_ready=1 -> all 3 results in order.
REQ-034 SHALL cover idle frame: empty FIFO at slot 0 -> opr_a/opr_b unchanged, no result captured, busy=0.
REQ-035 SHALL cover reset mid-frame: reset at slot 2 with frame in flight -> no out_valid afterwards, busy=0, frame_sync 1 cycle after reset release.
REQ-036 SHALL cover stats (OPR_HOST_STATS_EN): 256 results -> frames_done wraps to 0.
